// File: rtl/lag_measure.sv
// lag_measure: display input-lag meter.
// Times from a flash_start pulse to a debounced rising sensor level, in whole
// microseconds, and keeps min/max/count statistics of the accepted lags.
module lag_measure #(
  parameter int unsigned US_DIV     = 27,
  parameter int unsigned DEBOUNCE   = 16,
  parameter int unsigned TIMEOUT_US = 500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flash_start,
  input  logic             sensor_in,
  input  logic             clear,
  output logic [CNT_W-1:0] lag_us,
  output logic             lag_valid,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] min_us,
  output logic [CNT_W-1:0] max_us,
  output logic [7:0]       count
);

  localparam int unsigned PRESC_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(US_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [DB_W-1:0]    DEB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0]    DB_ONE     = DB_W'(1);
  localparam logic [DB_W-1:0]    DB_ZERO    = {DB_W{1'b0}};
  localparam logic [CNT_W-1:0]   US_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   US_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   US_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   TMO_VAL    = CNT_W'(TIMEOUT_US);

  typedef enum logic [1:0] {
    ST_WAIT_DARK = 2'd0,
    ST_ARMED     = 2'd1,
    ST_MEASURE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   us_q, us_d;
  logic [DB_W-1:0]    deb_q, deb_d;
  logic [CNT_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]   lag_us_q, lag_us_d;
  logic               lag_valid_q, lag_valid_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [7:0]         count_q, count_d;

  logic               accept_s;
  logic               tmo_s;
  logic [CNT_W-1:0]   acc_val_s;

  // Measurement FSM: dark qualification, arming, us timebase and sensor debounce.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    us_d      = us_q;
    deb_d     = deb_q;
    cand_d    = cand_q;
    accept_s  = 1'b0;
    tmo_s     = 1'b0;
    acc_val_s = cand_q;

    case (state_q)
      ST_WAIT_DARK: begin
        // deb counts consecutive dark samples; any light restarts the run
        if (sensor_in) begin
          deb_d = DB_ZERO;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = DB_ZERO;
          state_d = ST_ARMED;
        end else begin
          deb_d = deb_q + DB_ONE;
        end
      end

      ST_ARMED: begin
        // screen is proven dark; sensor is ignored until the flash starts
        if (flash_start) begin
          state_d = ST_MEASURE;
          presc_d = PRESC_ZERO;
          us_d    = US_ZERO;
          deb_d   = DB_ZERO;
        end else begin
          state_d = ST_ARMED;
        end
      end

      ST_MEASURE: begin
        // microsecond timebase, saturating at all ones
        if (presc_q == PRESC_LAST) begin
          presc_d = PRESC_ZERO;
          if (us_q == US_MAX) begin
            us_d = us_q;
          end else begin
            us_d = us_q + US_ONE;
          end
        end else begin
          presc_d = presc_q + PRESC_ONE;
          us_d    = us_q;
        end

        // deb counts consecutive light samples; the candidate is the run start time
        if (sensor_in) begin
          if (deb_q == DB_ZERO) begin
            cand_d    = us_q;
            acc_val_s = us_q;
          end else begin
            cand_d    = cand_q;
            acc_val_s = cand_q;
          end
          if (deb_q == DEB_LAST) begin
            accept_s = 1'b1;
            deb_d    = DB_ZERO;
          end else begin
            deb_d = deb_q + DB_ONE;
          end
        end else begin
          deb_d  = DB_ZERO;
          cand_d = cand_q;
        end

        // an accept in the timeout cycle still counts as a valid measurement
        if (accept_s) begin
          state_d = ST_WAIT_DARK;
        end else if (us_d >= TMO_VAL) begin
          tmo_s   = 1'b1;
          state_d = ST_WAIT_DARK;
          deb_d   = DB_ZERO;
        end else begin
          state_d = ST_MEASURE;
        end
      end

      default: begin
        state_d = ST_WAIT_DARK;
        deb_d   = DB_ZERO;
      end
    endcase
  end

  // Output pulses, last lag and statistics; clear overrides a same-cycle stats update.
  always_comb begin
    lag_valid_d = accept_s;
    timeout_d   = tmo_s;
    busy_d      = (state_d == ST_MEASURE);

    if (accept_s) begin
      lag_us_d = acc_val_s;
    end else begin
      lag_us_d = lag_us_q;
    end

    if (clear) begin
      min_d   = US_MAX;
      max_d   = US_ZERO;
      count_d = 8'd0;
    end else if (accept_s) begin
      if (acc_val_s < min_q) begin
        min_d = acc_val_s;
      end else begin
        min_d = min_q;
      end
      if (acc_val_s > max_q) begin
        max_d = acc_val_s;
      end else begin
        max_d = max_q;
      end
      if (count_q == 8'hFF) begin
        count_d = count_q;
      end else begin
        count_d = count_q + 8'd1;
      end
    end else begin
      min_d   = min_q;
      max_d   = max_q;
      count_d = count_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_WAIT_DARK;
      presc_q     <= PRESC_ZERO;
      us_q        <= US_ZERO;
      deb_q       <= DB_ZERO;
      cand_q      <= US_ZERO;
      lag_us_q    <= US_ZERO;
      lag_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      min_q       <= US_MAX;
      max_q       <= US_ZERO;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      us_q        <= us_d;
      deb_q       <= deb_d;
      cand_q      <= cand_d;
      lag_us_q    <= lag_us_d;
      lag_valid_q <= lag_valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      min_q       <= min_d;
      max_q       <= max_d;
      count_q     <= count_d;
    end
  end

  assign lag_us    = lag_us_q;
  assign lag_valid = lag_valid_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;
  assign min_us    = min_q;
  assign max_us    = max_q;
  assign count     = count_q;

endmodule
